lzrw1_input_scheduler: RTL and testbench



---
 rtl/lzrw1_input_scheduler.sv | 150 +++++++++++++++
 tb/tb_lzrw1_input_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzrw1_input_scheduler.sv
// lzrw1_input_scheduler
//   Feeds the LZRW1 compression core from two block-oriented byte sources.
//   Whole blocks are granted round-robin; each block is preceded by a
//   core_reset pulse, streamed byte by byte, then held until the core
//   reports finished_cycle (or a drain timeout expires).
//
// Ports
//   clock, reset      : clock, asynchronous active-low reset
//   req[1:0]          : requester i has a block pending
//   blk_len0/1        : block byte count, sampled on grant
//   src_valid[1:0]    : per-requester byte valid
//   src_byte0/1       : per-requester byte
//   src_ready[1:0]    : per-requester byte accept (combinational)
//   grant[1:0]        : one-hot owner of the core, 0 when idle
//   src_done[1:0]     : one-cycle pulse when requester i's block completes
//   core_reset        : active-high reset to the core
//   core_valid        : core valid input
//   core_byte         : core CurByte input
//   core_finished     : core finished_cycle
//   busy              : block in progress
//   timeout_err       : sticky drain-timeout flag
module lzrw1_input_scheduler #(
   parameter int unsigned LEN_W         = 12,
   parameter int unsigned CLR_CYCLES    = 2,
   parameter int unsigned DRAIN_TIMEOUT = 1024
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [LEN_W-1:0] blk_len0,
   input  logic [LEN_W-1:0] blk_len1,
   input  logic [1:0]       src_valid,
   input  logic [7:0]       src_byte0,
   input  logic [7:0]       src_byte1,
   output logic [1:0]       src_ready,
   output logic [1:0]       grant,
   output logic [1:0]       src_done,
   output logic             core_reset,
   output logic             core_valid,
   output logic [7:0]       core_byte,
   input  logic             core_finished,
   output logic             busy,
   output logic             timeout_err
);

   typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

   localparam int unsigned CW = $clog2(CLR_CYCLES + 1);
   localparam int unsigned DW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYCLES - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

   state_t           state;
   logic             owner;      // index of the granted requester
   logic             last;       // last served requester (round-robin pointer)
   logic [LEN_W-1:0] remaining;
   logic [CW-1:0]    clr_cnt;
   logic [DW-1:0]    drain_cnt;

   logic             pick;
   logic [LEN_W-1:0] pick_len;
   logic [7:0]       sel_byte;
   logic             xfer;

   always_comb begin
      // On a tie the requester not served last wins; otherwise the lone one.
      pick = req[1];
      if (req == 2'b11) pick = ~last;
      pick_len = pick ? blk_len1 : blk_len0;
      sel_byte = owner ? src_byte1 : src_byte0;
      src_ready = '0;
      if (state == STREAM && remaining != '0) src_ready = grant;
   end

   assign xfer = |(src_valid & src_ready);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last        <= 1'b1;
         remaining   <= '0;
         clr_cnt     <= '0;
         drain_cnt   <= '0;
         grant       <= '0;
         src_done    <= '0;
         core_reset  <= 1'b0;
         core_valid  <= 1'b0;
         core_byte   <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         src_done   <= '0;
         core_valid <= 1'b0;
         case (state)
            IDLE: begin
               grant <= '0;
               if (req != '0) begin
                  owner     <= pick;
                  grant     <= pick ? 2'b10 : 2'b01;
                  remaining <= pick_len;
                  if (pick_len == '0) begin
                     // Empty block: completes immediately, grant shown for one cycle.
                     src_done <= pick ? 2'b10 : 2'b01;
                     last     <= pick;
                  end else begin
                     state      <= CLEAR;
                     core_reset <= 1'b1;
                     busy       <= 1'b1;
                     clr_cnt    <= '0;
                  end
               end
            end
            CLEAR: begin
               if (clr_cnt == CLR_LAST) begin
                  core_reset <= 1'b0;
                  state      <= STREAM;
               end else begin
                  clr_cnt <= clr_cnt + CW'(1);
               end
            end
            STREAM: begin
               if (xfer) begin
                  core_valid <= 1'b1;
                  core_byte  <= sel_byte;
                  remaining  <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     state     <= DRAIN;
                     drain_cnt <= '0;
                  end
               end
            end
            DRAIN: begin
               if (core_finished || drain_cnt == DRAIN_LAST) begin
                  if (!core_finished) timeout_err <= 1'b1;
                  src_done <= grant;
                  grant    <= '0;
                  last     <= owner;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lzrw1_input_scheduler.sv
// Testbench for lzrw1_input_scheduler: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// block-level behavioural model.
module tb_lzrw1_input_scheduler;
   localparam int LEN_W = 12;
   localparam int CLR   = 2;
   localparam int TMO   = 16;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       req = '0;
   logic [LEN_W-1:0] blk_len0 = '0;
   logic [LEN_W-1:0] blk_len1 = '0;
   logic [1:0]       src_valid = '0;
   logic [7:0]       src_byte0 = '0;
   logic [7:0]       src_byte1 = '0;
   logic [1:0]       src_ready;
   logic [1:0]       grant;
   logic [1:0]       src_done;
   logic             core_reset;
   logic             core_valid;
   logic [7:0]       core_byte;
   logic             core_finished = 1'b0;
   logic             busy;
   logic             timeout_err;

   lzrw1_input_scheduler #(
      .LEN_W(LEN_W),
      .CLR_CYCLES(CLR),
      .DRAIN_TIMEOUT(TMO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .req(req),
      .blk_len0(blk_len0),
      .blk_len1(blk_len1),
      .src_valid(src_valid),
      .src_byte0(src_byte0),
      .src_byte1(src_byte1),
      .src_ready(src_ready),
      .grant(grant),
      .src_done(src_done),
      .core_reset(core_reset),
      .core_valid(core_valid),
      .core_byte(core_byte),
      .core_finished(core_finished),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   int errs = 0;
   int checks = 0;
   bit cmp_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Block-level model: a block is described by its owner, length, age
   // (cycles since grant), bytes sent and cycles spent waiting for the core.
   bit         m_active = 1'b0;
   bit         m_owner  = 1'b0;
   bit         m_last   = 1'b1;
   bit         m_w;
   int         m_len, m_age, m_sent, m_dage;
   logic [1:0] e_grant = '0, e_done = '0;
   logic       e_creset = 1'b0, e_cvalid = 1'b0, e_busy = 1'b0, e_terr = 1'b0;
   logic [7:0] e_cbyte = '0;

   always @(posedge clock) begin
      if (!reset) begin
         m_active = 1'b0; m_last = 1'b1;
         e_grant = '0; e_done = '0; e_creset = 1'b0; e_cvalid = 1'b0;
         e_busy = 1'b0; e_terr = 1'b0; e_cbyte = '0;
      end else begin
         e_done = '0; e_cvalid = 1'b0; e_creset = 1'b0;
         if (!m_active) begin
            e_grant = '0;
            if (req != 2'b00) begin
               m_w = (req == 2'b11) ? !m_last : req[1];
               m_owner = m_w;
               m_len = m_w ? int'(blk_len1) : int'(blk_len0);
               e_grant = 2'b01 << m_w;
               if (m_len == 0) begin
                  e_done = e_grant;
                  m_last = m_w;
               end else begin
                  m_active = 1'b1; m_age = 1; m_sent = 0; e_creset = 1'b1;
               end
            end
         end else begin
            if (m_age <= CLR) begin
               e_creset = (m_age < CLR);
            end else if (m_sent < m_len) begin
               if (src_valid[m_owner]) begin
                  e_cvalid = 1'b1;
                  e_cbyte = m_owner ? src_byte1 : src_byte0;
                  m_sent++;
                  m_dage = 0;
               end
            end else begin
               if (core_finished || m_dage == TMO - 1) begin
                  if (!core_finished) e_terr = 1'b1;
                  e_done = e_grant;
                  e_grant = '0;
                  m_last = m_owner;
                  m_active = 1'b0;
               end else begin
                  m_dage++;
               end
            end
            m_age++;
         end
         e_busy = m_active;
      end
   end

   function automatic logic [1:0] exp_ready();
      return (m_active && m_age > CLR && m_sent < m_len) ? e_grant : 2'b00;
   endfunction

   always @(negedge clock) begin
      if (cmp_on) begin
         chk("grant", grant, e_grant);
         chk("src_done", src_done, e_done);
         chk("core_reset", core_reset, e_creset);
         chk("core_valid", core_valid, e_cvalid);
         if (e_cvalid) chk("core_byte", core_byte, e_cbyte);
         chk("busy", busy, e_busy);
         chk("timeout_err", timeout_err, e_terr);
         chk("src_ready", src_ready, exp_ready());
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      req = '0; src_valid = 2'b11; core_finished = 1'b1;
      @(negedge clock);
      while ((busy || grant != 2'b00) && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk("idle_reached", {busy, grant}, 0);
      core_finished = 1'b0; src_valid = '0;
   endtask

   logic [1:0] gseq [3];
   logic [7:0] vb [4];
   logic       cvp [5];
   int         pat [5] = '{1, 0, 0, 1, 1};

   initial begin
      int n, ng, nrise, k, nres, nv, first_v, last_v;
      logic [1:0] prev_g;
      logic prev_r;

      for (int i = 0; i < 3; i++) gseq[i] = '0;
      for (int i = 0; i < 4; i++) vb[i] = '0;

      // Reset
      #1 reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_grant", grant, 0);
      chk("rst_done", src_done, 0);
      chk("rst_creset", core_reset, 0);
      chk("rst_cvalid", core_valid, 0);
      chk("rst_cbyte", core_byte, 0);
      chk("rst_busy", busy, 0);
      chk("rst_terr", timeout_err, 0);
      #2 reset = 1'b1;
      cmp_on = 1'b1;
      @(negedge clock);

      // Contention: ch0, ch1, ch0
      blk_len0 = 12'd3; blk_len1 = 12'd3; req = 2'b11; src_valid = 2'b11; core_finished = 1'b1;
      ng = 0; nrise = 0; prev_g = '0; prev_r = 1'b0;
      for (int c = 0; c < 80 && ng < 3; c++) begin
         @(negedge clock);
         if (core_reset && !prev_r) nrise++;
         if (grant != 2'b00 && prev_g == 2'b00) begin
            gseq[ng] = grant;
            chk("cont_reset_with_grant", core_reset, 1);
            ng++;
            if (ng == 3) req = '0;
         end
         if (core_valid) chk("cont_byte_owner", core_byte[7:4], grant[1] ? 4'hB : 4'hA);
         prev_g = grant; prev_r = core_reset;
         src_byte0 = 8'hA0 | 8'($urandom_range(0, 15));
         src_byte1 = 8'hB0 | 8'($urandom_range(0, 15));
      end
      chk("cont_grants", ng, 3);
      chk("cont_g0", gseq[0], 2'b01);
      chk("cont_g1", gseq[1], 2'b10);
      chk("cont_g2", gseq[2], 2'b01);
      chk("cont_resets", nrise, 3);
      wait_idle();

      // Single block, 4 bytes 41..44
      req = 2'b01; blk_len0 = 12'd4; src_valid = 2'b01; core_finished = 1'b0;
      src_byte0 = 8'h41; k = 0; nres = 0; nv = 0; first_v = -1; last_v = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (core_reset) nres++;
         if (core_valid) begin
            if (nv < 4) vb[nv] = core_byte;
            if (first_v < 0) first_v = c;
            last_v = c;
            nv++;
         end
         if (grant != 2'b00) req = '0;
         if (nv == 4 && c == last_v + 6) begin
            chk("single_done", src_done, 2'b01);
            chk("single_busy", busy, 0);
         end
         core_finished = (nv == 4 && c == last_v + 5);
         src_byte0 = 8'h41 + 8'(k);
         if (src_ready[0]) k++;
      end
      chk("single_resets", nres, 2);
      chk("single_nbytes", nv, 4);
      chk("single_consec", last_v - first_v, 3);
      chk("single_b0", vb[0], 8'h41);
      chk("single_b1", vb[1], 8'h42);
      chk("single_b2", vb[2], 8'h43);
      chk("single_b3", vb[3], 8'h44);
      wait_idle();

      // Source bubbles on ch1
      req = 2'b10; blk_len1 = 12'd3; src_valid = '0; core_finished = 1'b0;
      n = 0;
      while (!src_ready[1] && n < 20) begin
         @(negedge clock);
         if (grant != 2'b00) req = '0;
         n++;
      end
      chk("bubble_ready", src_ready[1], 1);
      for (int p = 0; p < 6; p++) begin
         if (p > 0) begin
            @(negedge clock);
            cvp[p-1] = core_valid;
         end
         if (p < 5) begin
            src_valid = (pat[p] != 0) ? 2'b10 : 2'b00;
            src_byte1 = 8'($urandom);
         end
      end
      src_valid = '0;
      for (int p = 0; p < 5; p++) chk("bubble_cvalid", cvp[p], pat[p]);
      chk("bubble_drain_busy", busy, 1);
      chk("bubble_drain_ready", src_ready, 0);
      core_finished = 1'b1;
      @(negedge clock);
      core_finished = 1'b0;
      chk("bubble_done", src_done, 2'b10);
      wait_idle();

      // Zero length
      req = 2'b01; blk_len0 = '0;
      n = 0;
      @(negedge clock);
      while (grant == 2'b00 && n < 10) begin
         @(negedge clock);
         n++;
      end
      req = '0;
      chk("zero_grant", grant, 2'b01);
      chk("zero_done", src_done, 2'b01);
      chk("zero_creset", core_reset, 0);
      chk("zero_busy", busy, 0);
      @(negedge clock);
      chk("zero_grant_drop", grant, 0);
      chk("zero_cvalid", core_valid, 0);
      chk("zero_creset2", core_reset, 0);

      // Drain timeout
      req = 2'b01; blk_len0 = 12'd1; src_valid = 2'b01; core_finished = 1'b0;
      n = 0;
      @(negedge clock);
      while (!core_valid && n < 20) begin
         if (grant != 2'b00) req = '0;
         @(negedge clock);
         n++;
      end
      req = '0;
      chk("tmo_entry", core_valid, 1);
      n = 0;
      while (!timeout_err && n < 40) begin
         @(negedge clock);
         n++;
      end
      chk("tmo_delay", n, TMO);
      chk("tmo_done", src_done, 2'b01);
      @(negedge clock);
      chk("tmo_sticky", timeout_err, 1);
      req = 2'b10; blk_len1 = 12'd1;
      n = 0;
      while (grant == 2'b00 && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("tmo_next_grant", grant, 2'b10);
      wait_idle();

      // Randomized traffic, then a stretch with no core_finished
      for (int c = 0; c < 2000; c++) begin
         @(negedge clock);
         req = 2'($urandom_range(0, 3));
         blk_len0 = ($urandom_range(0, 6) == 0) ? '0 : 12'($urandom_range(1, 6));
         blk_len1 = ($urandom_range(0, 6) == 0) ? '0 : 12'($urandom_range(1, 6));
         src_valid = 2'($urandom_range(0, 3));
         src_byte0 = 8'($urandom);
         src_byte1 = 8'($urandom);
         core_finished = (c < 1500) ? ($urandom_range(0, 4) == 0) : 1'b0;
      end
      wait_idle();

      // Reset during the 2nd byte of a 10-byte block
      req = 2'b01; blk_len0 = 12'd10; src_valid = 2'b01; core_finished = 1'b0;
      n = 0;
      @(negedge clock);
      while (!core_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("mid_first_byte", core_valid, 1);
      @(negedge clock);
      chk("mid_second_byte", core_valid, 1);
      #2 reset = 1'b0; req = 2'b11;
      #1;
      chk("mid_grant", grant, 0);
      chk("mid_done", src_done, 0);
      chk("mid_creset", core_reset, 0);
      chk("mid_cvalid", core_valid, 0);
      chk("mid_cbyte", core_byte, 0);
      chk("mid_busy", busy, 0);
      chk("mid_terr", timeout_err, 0);
      chk("mid_ready", src_ready, 0);
      repeat (2) @(negedge clock);
      #2 reset = 1'b1;
      n = 0;
      while (grant == 2'b00 && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("mid_post_grant", grant, 2'b01);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
